axi_wr_scheduler: RTL and testbench

AXI_WR_SCHEDULER -- requirements
Module: axi_wr_scheduler

---
 rtl/axi_wr_scheduler.sv | 143 ++++++++++++++
 tb/tb_axi_wr_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_scheduler.sv
// rtl/axi_wr_scheduler.sv - two-requester AXI write burst scheduler, one burst in flight
// Optional macro AXI_WR_SCHED_RR_EN: round-robin arbitration instead of fixed priority to requester 0.
module axi_wr_scheduler #(
    parameter int ASIZE = 32,
    parameter int DSIZE = 64,
    parameter int LSIZE = 8
) (
    input  logic                 axi_aclk,
    input  logic                 axi_areset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*ASIZE-1:0]   req_addr,
    input  logic [2*LSIZE-1:0]   req_len,
    input  logic [2*DSIZE-1:0]   wr_data,
    input  logic [1:0]           wr_valid,
    output logic [1:0]           wr_ready,
    output logic [1:0]           resp_valid,
    output logic [1:0]           resp_code,
    output logic [ASIZE-1:0]     m_awaddr,
    output logic [LSIZE-1:0]     m_awlen,
    output logic [2:0]           m_awsize,
    output logic [1:0]           m_awburst,
    output logic                 m_awvalid,
    input  logic                 m_awready,
    output logic [DSIZE-1:0]     m_wdata,
    output logic [DSIZE/8-1:0]   m_wstrb,
    output logic                 m_wlast,
    output logic                 m_wvalid,
    input  logic                 m_wready,
    input  logic [1:0]           m_bresp,
    input  logic                 m_bvalid,
    output logic                 m_bready
);
    localparam logic [2:0] AWSIZE = 3'($clog2(DSIZE / 8));

    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

    state_t           state, state_nxt;
    logic             grant, grant_nxt;
    logic [ASIZE-1:0] addr_q;
    logic [LSIZE-1:0] len_q;
    logic [LSIZE-1:0] beat_cnt;
    logic             accept, beat_hs, at_last;

    // A command is never accepted while reset is held, so outputs stay quiet during reset.
    assign accept  = (state == IDLE) && (|req_valid) && !axi_areset;
    assign at_last = (beat_cnt == len_q);
    assign beat_hs = (state == W) && wr_valid[grant] && m_wready;

`ifdef AXI_WR_SCHED_RR_EN
    logic prio;

    assign grant_nxt = (&req_valid) ? prio : ~req_valid[0];

    // prio names the requester that wins the next tie: the one not served last.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            prio <= 1'b0;
        end else if (accept) begin
            prio <= ~grant_nxt;
        end
    end
`else
    assign grant_nxt = ~req_valid[0];
`endif

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state    <= IDLE;
            grant    <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant    <= grant_nxt;
                addr_q   <= grant_nxt ? req_addr[2*ASIZE-1:ASIZE] : req_addr[ASIZE-1:0];
                len_q    <= grant_nxt ? req_len[2*LSIZE-1:LSIZE] : req_len[LSIZE-1:0];
                beat_cnt <= '0;
            end
            // Counter clears on the last beat, so a full-length burst never wraps.
            if (beat_hs) begin
                beat_cnt <= at_last ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        wr_ready   = '0;
        resp_valid = '0;
        resp_code  = '0;
        m_awaddr   = '0;
        m_awlen    = '0;
        m_awsize   = '0;
        m_awburst  = '0;
        m_awvalid  = 1'b0;
        m_wdata    = '0;
        m_wstrb    = '0;
        m_wlast    = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready[grant_nxt] = 1'b1;
                    state_nxt            = AW;
                end
            end
            AW: begin
                m_awvalid = 1'b1;
                m_awaddr  = addr_q;
                m_awlen   = len_q;
                m_awsize  = AWSIZE;
                m_awburst = 2'b01;
                if (m_awready) begin
                    state_nxt = W;
                end
            end
            W: begin
                m_wvalid        = wr_valid[grant];
                m_wdata         = grant ? wr_data[2*DSIZE-1:DSIZE] : wr_data[DSIZE-1:0];
                m_wstrb         = '1;
                m_wlast         = at_last;
                wr_ready[grant] = m_wready;
                if (beat_hs && at_last) begin
                    state_nxt = B;
                end
            end
            B: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    resp_valid[grant] = 1'b1;
                    resp_code         = m_bresp;
                    state_nxt         = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_wr_scheduler.sv
// tb/tb_axi_wr_scheduler.sv - scoreboard bench for axi_wr_scheduler
module tb_axi_wr_scheduler;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_ready;
    logic [63:0]  req_addr = '0;
    logic [15:0]  req_len = '0;
    logic [127:0] wr_data = '0;
    logic [1:0]   wr_valid = '0;
    logic [1:0]   wr_ready, resp_valid, resp_code;
    logic [31:0]  m_awaddr;
    logic [7:0]   m_awlen;
    logic [2:0]   m_awsize;
    logic [1:0]   m_awburst;
    logic         m_awvalid;
    logic         m_awready = 1'b0;
    logic [63:0]  m_wdata;
    logic [7:0]   m_wstrb;
    logic         m_wlast, m_wvalid;
    logic         m_wready = 1'b0;
    logic [1:0]   m_bresp = '0;
    logic         m_bvalid = 1'b0;
    logic         m_bready;

    int compared = 0;
    int mismatched = 0;
    logic [39:0] exp_aw[$];
    logic [64:0] exp_w[$];
    logic [2:0]  exp_resp[$];
    int         aw_delay = 0;
    bit         w_toggle = 1'b0;
    bit         gaps = 1'b0;
    logic [1:0] bresp_cfg = '0;
    int         epoch = 0;
    int         beat[2];

    always #5 clk = ~clk;

    axi_wr_scheduler #(.ASIZE(32), .DSIZE(64), .LSIZE(8)) dut (
        .axi_aclk(clk), .axi_areset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .resp_valid(resp_valid), .resp_code(resp_code),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    function automatic logic [63:0] data_of(input int i, input int b);
        return 64'hD0D0_0000_0000_0000 | (64'(i) << 40) | 64'(b);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got unexpected transfer required none", name);
    endtask

    // Write sources: beat index advances on each accepted beat, restarts when epoch bumps.
    initial begin
        int seen = 0;
        logic [1:0] hs;
        int cyc = 0;
        beat[0] = 0;
        beat[1] = 0;
        forever begin
            @(negedge clk);
            hs = wr_valid & wr_ready;
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (epoch != seen) beat[i] = 0;
                else if (hs[i]) beat[i]++;
                wr_data[i*64 +: 64] = data_of(i, beat[i]);
                wr_valid[i] = !(gaps && (cyc % 3 == 1));
            end
            seen = epoch;
        end
    end

    // AXI slave model.
    initial begin
        int aw_wait = 0;
        int tog = 0;
        forever begin
            @(posedge clk);
            #1;
            tog++;
            if (m_awvalid) aw_wait++;
            else aw_wait = 0;
            m_awready = m_awvalid && (aw_wait > aw_delay);
            m_wready  = w_toggle ? (tog % 2 == 0) : 1'b1;
            m_bvalid  = m_bready;
            m_bresp   = m_bready ? bresp_cfg : 2'b00;
        end
    end

    // Monitor: compares every presented transfer against the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_awvalid) begin
                if (exp_aw.size() == 0) unexpected("aw");
                else begin
                    chk("awaddr", m_awaddr, exp_aw[0][39:8]);
                    chk("awlen", m_awlen, exp_aw[0][7:0]);
                    chk("awsize", m_awsize, 3);
                    chk("awburst", m_awburst, 1);
                    if (m_awready) void'(exp_aw.pop_front());
                end
            end
            if (m_wvalid) begin
                if (exp_w.size() == 0) unexpected("w");
                else begin
                    chk("wdata", m_wdata, exp_w[0][63:0]);
                    chk("wlast", m_wlast, exp_w[0][64]);
                    chk("wstrb", m_wstrb, 8'hFF);
                    if (m_wready) void'(exp_w.pop_front());
                end
            end
            if (resp_valid != 2'b00) begin
                if (exp_resp.size() == 0) unexpected("resp");
                else begin
                    chk("resp_valid", resp_valid, 2'b01 << exp_resp[0][2]);
                    chk("resp_code", resp_code, exp_resp[0][1:0]);
                    void'(exp_resp.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((exp_aw.size() + exp_w.size() + exp_resp.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 3000) begin
            mismatched++;
            $display("FAIL drain: got %0d/%0d/%0d pending required 0", exp_aw.size(), exp_w.size(), exp_resp.size());
            exp_aw.delete();
            exp_w.delete();
            exp_resp.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 100);
        chk("req_ready", req_ready[i], 1);
    endtask

    task automatic restart_sources();
        epoch++;
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [7:0] l, input logic [1:0] br);
        restart_sources();
        bresp_cfg = br;
        exp_aw.push_back({a, l});
        for (int b = 0; b <= int'(l); b++) exp_w.push_back({b == int'(l), data_of(i, b)});
        exp_resp.push_back({1'(i), br});
        req_addr[i*32 +: 32] = a;
        req_len[i*8 +: 8]    = l;
        req_valid[i]         = 1'b1;
        wait_ready(i);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        wait_idle();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_awvalid"}, m_awvalid, 0);
        chk({tag, "_awaddr"}, m_awaddr, 0);
        chk({tag, "_awlen"}, m_awlen, 0);
        chk({tag, "_wvalid"}, m_wvalid, 0);
        chk({tag, "_wlast"}, m_wlast, 0);
        chk({tag, "_wdata"}, m_wdata, 0);
        chk({tag, "_wstrb"}, m_wstrb, 0);
        chk({tag, "_bready"}, m_bready, 0);
    endtask

    task automatic arb_test();
        int nb[2] = '{0, 0};
        int g;
        restart_sources();
        bresp_cfg = 2'b00;
        for (int k = 0; k < 4; k++) begin
`ifdef AXI_WR_SCHED_RR_EN
            g = k % 2;
`else
            g = 0;
`endif
            exp_aw.push_back({(g == 1) ? 32'h200 : 32'h100, 8'd0});
            exp_w.push_back({1'b1, data_of(g, nb[g])});
            nb[g]++;
            exp_resp.push_back({1'(g), 2'b00});
        end
        req_addr  = {32'h200, 32'h100};
        req_len   = '0;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (req_ready == 2'b00 && n < 100);
            chk("arb_grant", req_ready != 2'b00, 1);
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        wait_idle();
    endtask

    task automatic reset_mid_burst();
        int n = 0;
        restart_sources();
        exp_aw.push_back({32'h4000, 8'd7});
        exp_w.push_back({1'b0, data_of(0, 0)});
        exp_w.push_back({1'b0, data_of(0, 1)});
        req_addr[31:0] = 32'h4000;
        req_len[7:0]   = 8'd7;
        req_valid[0]   = 1'b1;
        wait_ready(0);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (beat[0] != 1 && n < 100);
        chk("rst_setup_beat", beat[0], 1);
        #1 rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        #1 rst = 1'b0;
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        issue(0, 32'h1000, 8'd3, 2'b00);
        aw_delay = 5;
        issue(1, 32'h2040, 8'd0, 2'b00);
        aw_delay = 0;
        gaps     = 1'b1;
        w_toggle = 1'b1;
        issue(0, 32'h5000, 8'd7, 2'b00);
        gaps     = 1'b0;
        w_toggle = 1'b0;
        issue(1, 32'h6000, 8'd1, 2'b10);
        issue(1, 32'h7000, 8'd255, 2'b00);
        arb_test();
        reset_mid_burst();
        issue(0, 32'h3000, 8'd1, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
